// File: rtl/mem_arbiter_m1_pkg.sv
// Shared types for the two-port memory arbiter: request record, mode codes, FSM states.
package m1_mem_pkg;

  typedef struct packed {
    logic [15:0] data;
    logic [14:0] address;
    logic [1:0]  mask;
    logic [1:0]  fnc_type;
    logic [1:0]  mode;
    logic [3:0]  wb_dest;
  } mem_req_t;

  localparam mem_req_t   MEM_REQ_ZERO   = 41'd0;
  localparam logic [1:0] MODE_READ      = 2'd0;
  localparam logic [1:0] MODE_WRITE     = 2'd1;
  localparam logic [1:0] MODE_FENCE     = 2'd2;
  localparam logic [1:0] MODE_FENCE_ALT = 2'd3;

  typedef enum logic [1:0] {
    ARB         = 2'd0,
    FENCE_DRAIN = 2'd1,
    FENCE_WAIT  = 2'd2
  } arb_state_t;

  function automatic logic is_fence(input logic [1:0] mode);
    return (mode == MODE_FENCE) || (mode == MODE_FENCE_ALT);
  endfunction

endpackage

// File: rtl/mem_arbiter_m1_req_fifo.sv
// Two-entry request FIFO; a write that coincides with a pop is accepted even when full.
module req_fifo_m1
  import m1_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       wr_en,
  input  mem_req_t   wr_data,
  input  logic       rd_en,
  output mem_req_t   head,
  output logic [1:0] count,
  output logic       overflow
);

  mem_req_t   mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;
  logic       full_s;
  logic       do_rd_s;
  logic       do_wr_s;

  assign full_s   = (count_r == 2'd2);
  assign do_rd_s  = clk_en && rd_en && (count_r != 2'd0);
  assign do_wr_s  = clk_en && wr_en && (!full_s || do_rd_s);
  assign overflow = clk_en && wr_en && full_s && !do_rd_s;
  assign head     = mem_r[rd_ptr_r];
  assign count    = count_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= MEM_REQ_ZERO;
      mem_r[1] <= MEM_REQ_ZERO;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_wr_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_rd_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter_m1.sv
// Two-port round-robin memory arbiter with fence ordering and in-order read response routing.
module mem_arbiter_m1
  import m1_mem_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        p0_enable,
  input  logic        p1_enable,
  input  mem_req_t    p0_req,
  input  mem_req_t    p1_req,
  output logic        p0_available,
  output logic        p1_available,
  input  logic        p0_input_ready,
  input  logic        p1_input_ready,
  output logic        p0_read_ack,
  output logic        p1_read_ack,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_wb_dest,
  output mem_req_t    mem_req,
  output logic        mem_enable,
  input  logic        mem_available,
  input  logic        mem_idle,
  input  logic        mem_read_ack,
  input  logic [15:0] mem_data_in,
  input  logic [3:0]  mem_wb_dest_in,
  output logic        mem_input_ready,
  output logic        arb_idle,
  output logic        err
);

  localparam int              RSP_AW   = $clog2(RSP_DEPTH);
  localparam logic [RSP_AW:0] RSP_FULL = (RSP_AW + 1)'(RSP_DEPTH);
  localparam logic [RSP_AW:0] RSP_ZERO = (RSP_AW + 1)'(0);

  mem_req_t   head0_s, head1_s, grant_head_s;
  logic [1:0] cnt0_s, cnt1_s;
  logic       ovf0_s, ovf1_s, pop0_s, pop1_s;

  arb_state_t state_r, state_nxt_s;
  logic       prio_r, fence_port_r;
  logic [1:0] wait_cnt_r;
  logic       cand0_s, cand1_s, win_port_s, win_valid_s, win_fence_s;
  logic       grant_s, grant_port_s, enter_fence_s, fence_grant_s;

  logic              rsp_mem_r [RSP_DEPTH];
  logic [RSP_AW-1:0] rsp_wr_ptr_r, rsp_rd_ptr_r;
  logic [RSP_AW:0]   rsp_cnt_r;
  logic              rsp_empty_s, rsp_full_s, rsp_head_s, rsp_push_s, ack_ok_s, ack_err_s;

  req_fifo_m1 u_fifo0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(p0_enable), .wr_data(p0_req),
    .rd_en(pop0_s), .head(head0_s), .count(cnt0_s), .overflow(ovf0_s)
  );

  req_fifo_m1 u_fifo1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(p1_enable), .wr_data(p1_req),
    .rd_en(pop1_s), .head(head1_s), .count(cnt1_s), .overflow(ovf1_s)
  );

  assign p0_available = (cnt0_s + {1'b0, p0_enable}) < 2'd2;
  assign p1_available = (cnt1_s + {1'b0, p1_enable}) < 2'd2;

  assign rsp_empty_s = (rsp_cnt_r == RSP_ZERO);
  assign rsp_full_s  = (rsp_cnt_r == RSP_FULL);
  assign rsp_head_s  = rsp_mem_r[rsp_rd_ptr_r];

  // Fences stay candidates so that winning the round-robin can start the drain.
  assign cand0_s     = (cnt0_s != 2'd0) && !((head0_s.mode == MODE_READ) && rsp_full_s);
  assign cand1_s     = (cnt1_s != 2'd0) && !((head1_s.mode == MODE_READ) && rsp_full_s);
  assign win_valid_s = cand0_s || cand1_s;
  assign win_port_s  = prio_r ? cand1_s : !cand0_s;
  assign win_fence_s = win_port_s ? is_fence(head1_s.mode) : is_fence(head0_s.mode);

  always_comb begin
    state_nxt_s   = state_r;
    grant_s       = 1'b0;
    grant_port_s  = 1'b0;
    enter_fence_s = 1'b0;
    fence_grant_s = 1'b0;
    case (state_r)
      ARB: begin
        if (mem_available && win_valid_s) begin
          if (win_fence_s) begin
            enter_fence_s = 1'b1;
            state_nxt_s   = FENCE_DRAIN;
          end else begin
            grant_s      = 1'b1;
            grant_port_s = win_port_s;
          end
        end else begin
          state_nxt_s = ARB;
        end
      end
      FENCE_DRAIN: begin
        if (rsp_empty_s && !mem_enable && mem_idle && mem_available) begin
          grant_s       = 1'b1;
          grant_port_s  = fence_port_r;
          fence_grant_s = 1'b1;
          state_nxt_s   = FENCE_WAIT;
        end else begin
          state_nxt_s = FENCE_DRAIN;
        end
      end
      FENCE_WAIT: begin
        if ((wait_cnt_r == 2'd2) && mem_idle) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = FENCE_WAIT;
        end
      end
      default: state_nxt_s = ARB;
    endcase
  end

  assign grant_head_s = grant_port_s ? head1_s : head0_s;
  assign pop0_s       = grant_s && !grant_port_s;
  assign pop1_s       = grant_s && grant_port_s;
  assign rsp_push_s   = clk_en && grant_s && (grant_head_s.mode == MODE_READ);
  assign ack_ok_s     = clk_en && mem_read_ack && !rsp_empty_s;
  assign ack_err_s    = clk_en && mem_read_ack && rsp_empty_s;

  assign p0_read_ack     = ack_ok_s && !rsp_head_s;
  assign p1_read_ack     = ack_ok_s && rsp_head_s;
  assign rsp_data        = mem_data_in;
  assign rsp_wb_dest     = mem_wb_dest_in;
  assign mem_input_ready = rsp_empty_s ? 1'b1 : (rsp_head_s ? p1_input_ready : p0_input_ready);
  assign arb_idle        = (cnt0_s == 2'd0) && (cnt1_s == 2'd0) && rsp_empty_s &&
                           !mem_enable && (state_r == ARB) && mem_idle;

  // wait_cnt_r counts cycles since the fence grant, saturating at 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB;
      prio_r       <= 1'b0;
      fence_port_r <= 1'b0;
      wait_cnt_r   <= 2'd0;
    end else if (clk_en) begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        prio_r <= ~grant_port_s;
      end
      if (enter_fence_s) begin
        fence_port_r <= win_port_s;
      end
      if (fence_grant_s) begin
        wait_cnt_r <= 2'd1;
      end else if ((state_r == FENCE_WAIT) && (wait_cnt_r != 2'd2)) begin
        wait_cnt_r <= wait_cnt_r + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= MEM_REQ_ZERO;
      mem_enable <= 1'b0;
      err        <= 1'b0;
    end else if (clk_en) begin
      mem_enable <= grant_s;
      if (grant_s) begin
        mem_req <= grant_head_s;
      end
      if (ovf0_s || ovf1_s || ack_err_s) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        rsp_mem_r[i] <= 1'b0;
      end
      rsp_wr_ptr_r <= {RSP_AW{1'b0}};
      rsp_rd_ptr_r <= {RSP_AW{1'b0}};
      rsp_cnt_r    <= RSP_ZERO;
    end else begin
      if (rsp_push_s) begin
        rsp_mem_r[rsp_wr_ptr_r] <= grant_port_s;
        rsp_wr_ptr_r            <= rsp_wr_ptr_r + 1'b1;
      end
      if (ack_ok_s) begin
        rsp_rd_ptr_r <= rsp_rd_ptr_r + 1'b1;
      end
      case ({rsp_push_s, ack_ok_s})
        2'b10:   rsp_cnt_r <= rsp_cnt_r + 1'b1;
        2'b01:   rsp_cnt_r <= rsp_cnt_r - 1'b1;
        default: rsp_cnt_r <= rsp_cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_m1.sv
// Directed bench for mem_arbiter_m1: cycle table for alternating writes, hand sequences for the rest.
module tb_mem_arbiter_m1;
  import m1_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, p0_enable, p1_enable;
  mem_req_t    p0_req, p1_req, mem_req;
  logic        p0_available, p1_available, p0_input_ready, p1_input_ready;
  logic        p0_read_ack, p1_read_ack, mem_enable, mem_available, mem_idle, mem_read_ack;
  logic [15:0] rsp_data, mem_data_in;
  logic [3:0]  rsp_wb_dest, mem_wb_dest_in;
  logic        mem_input_ready, arb_idle, err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       p0_en;
    logic [3:0] p0_tag;
    logic       p1_en;
    logic [3:0] p1_tag;
    logic       exp_p0_av;
    logic       exp_p1_av;
    logic       exp_en;
    logic [3:0] exp_tag;
  } vec_t;

  vec_t vecs [8];

  mem_arbiter_m1 #(.RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .p0_enable(p0_enable), .p1_enable(p1_enable), .p0_req(p0_req), .p1_req(p1_req),
    .p0_available(p0_available), .p1_available(p1_available),
    .p0_input_ready(p0_input_ready), .p1_input_ready(p1_input_ready),
    .p0_read_ack(p0_read_ack), .p1_read_ack(p1_read_ack),
    .rsp_data(rsp_data), .rsp_wb_dest(rsp_wb_dest),
    .mem_req(mem_req), .mem_enable(mem_enable),
    .mem_available(mem_available), .mem_idle(mem_idle), .mem_read_ack(mem_read_ack),
    .mem_data_in(mem_data_in), .mem_wb_dest_in(mem_wb_dest_in),
    .mem_input_ready(mem_input_ready), .arb_idle(arb_idle), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic mem_req_t mk(input logic [1:0] mode, input logic [3:0] tag);
    mem_req_t r;
    r          = MEM_REQ_ZERO;
    r.mode     = mode;
    r.wb_dest  = tag;
    r.data     = {12'h000, tag};
    r.address  = {11'd0, tag};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    p0_enable    = 1'b0;
    p1_enable    = 1'b0;
    mem_read_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_tags [4];
    logic       exp_heads [4];

    rst_n = 1'b0; clk_en = 1'b1; idle_in();
    p0_req = MEM_REQ_ZERO; p1_req = MEM_REQ_ZERO;
    mem_available = 1'b1; mem_idle = 1'b1;
    mem_data_in = 16'h0000; mem_wb_dest_in = 4'd0;
    p0_input_ready = 1'b1; p1_input_ready = 1'b1;

    // p0/p1 write tags 1,2,3 / 9,10,11; grants must alternate p0,p1.
    vecs[0] = '{1'b1, 4'd1, 1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 4'd0};
    vecs[1] = '{1'b1, 4'd2, 1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 4'd1};
    vecs[2] = '{1'b1, 4'd3, 1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 4'd9};
    vecs[3] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd2};
    vecs[4] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd10};
    vecs[5] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd3};
    vecs[6] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd11};
    vecs[7] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd11};

    #12;
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_mem_req_zero", 32'(mem_req != MEM_REQ_ZERO), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_arb_idle", 32'(arb_idle), 32'd1);
    check("rst_mem_input_ready", 32'(mem_input_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      p0_enable = vecs[i].p0_en; p0_req = mk(MODE_WRITE, vecs[i].p0_tag);
      p1_enable = vecs[i].p1_en; p1_req = mk(MODE_WRITE, vecs[i].p1_tag);
      #1;
      check($sformatf("v%0d_p0_available", i), 32'(p0_available), 32'(vecs[i].exp_p0_av));
      check($sformatf("v%0d_p1_available", i), 32'(p1_available), 32'(vecs[i].exp_p1_av));
      tick();
      check($sformatf("v%0d_mem_enable", i), 32'(mem_enable), 32'(vecs[i].exp_en));
      check($sformatf("v%0d_mem_wb_dest", i), 32'(mem_req.wb_dest), 32'(vecs[i].exp_tag));
    end
    idle_in();
    #1;
    check("wr_alt_err", 32'(err), 32'd0);
    check("wr_alt_arb_idle", 32'(arb_idle), 32'd1);

    // Reads from p1 then p0, acked in order.
    p1_enable = 1'b1; p1_req = mk(MODE_READ, 4'd5); tick(); p1_enable = 1'b0;
    p0_enable = 1'b1; p0_req = mk(MODE_READ, 4'd6); tick(); p0_enable = 1'b0;
    check("rd_p1_issue_en", 32'(mem_enable), 32'd1);
    check("rd_p1_issue_tag", 32'(mem_req.wb_dest), 32'd5);
    tick();
    check("rd_p0_issue_tag", 32'(mem_req.wb_dest), 32'd6);
    p1_input_ready = 1'b0; #1;
    check("rd_input_ready_head_p1", 32'(mem_input_ready), 32'd0);
    p1_input_ready = 1'b1;
    mem_read_ack = 1'b1; mem_data_in = 16'hA5A5; mem_wb_dest_in = 4'd5; #1;
    check("rd_ack1_p1", 32'(p1_read_ack), 32'd1);
    check("rd_ack1_p0", 32'(p0_read_ack), 32'd0);
    check("rd_ack1_data", 32'(rsp_data), 32'h0000A5A5);
    check("rd_ack1_dest", 32'(rsp_wb_dest), 32'd5);
    tick();
    mem_data_in = 16'h1234; mem_wb_dest_in = 4'd6; #1;
    check("rd_ack2_p0", 32'(p0_read_ack), 32'd1);
    check("rd_ack2_p1", 32'(p1_read_ack), 32'd0);
    check("rd_ack2_data", 32'(rsp_data), 32'h00001234);
    tick(); mem_read_ack = 1'b0; #1;
    check("rd_input_ready_empty", 32'(mem_input_ready), 32'd1);
    check("rd_err", 32'(err), 32'd0);

    // Four reads fill the response FIFO; a later write bypasses a held read.
    mem_available = 1'b0;
    p0_enable = 1'b1; p0_req = mk(MODE_READ, 4'd1); p1_enable = 1'b1; p1_req = mk(MODE_READ, 4'd3); tick();
    p0_req = mk(MODE_READ, 4'd2); p1_req = mk(MODE_READ, 4'd4); tick();
    idle_in(); mem_available = 1'b1;
    exp_tags = '{4'd3, 4'd1, 4'd4, 4'd2};
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("full_fill%0d_en", i), 32'(mem_enable), 32'd1);
      check($sformatf("full_fill%0d_tag", i), 32'(mem_req.wb_dest), 32'(exp_tags[i]));
    end
    p0_enable = 1'b1; p0_req = mk(MODE_READ, 4'd5); p1_enable = 1'b1; p1_req = mk(MODE_WRITE, 4'd6); tick();
    idle_in();
    check("full_enqueue_no_grant", 32'(mem_enable), 32'd0);
    tick();
    check("full_write_issued_en", 32'(mem_enable), 32'd1);
    check("full_write_issued_tag", 32'(mem_req.wb_dest), 32'd6);
    tick();
    check("full_read_held", 32'(mem_enable), 32'd0);
    mem_read_ack = 1'b1; mem_data_in = 16'h1111; mem_wb_dest_in = 4'd3; #1;
    check("full_ack_p1", 32'(p1_read_ack), 32'd1);
    tick(); mem_read_ack = 1'b0;
    check("full_read_held_in_ack_cycle", 32'(mem_enable), 32'd0);
    tick();
    check("full_read_released_en", 32'(mem_enable), 32'd1);
    check("full_read_released_tag", 32'(mem_req.wb_dest), 32'd5);
    exp_heads = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      mem_read_ack = 1'b1; #1;
      check($sformatf("drain%0d_p1_ack", i), 32'(p1_read_ack), 32'(exp_heads[i]));
      check($sformatf("drain%0d_p0_ack", i), 32'(p0_read_ack), 32'(!exp_heads[i]));
      tick();
    end
    mem_read_ack = 1'b0;
    check("drain_err", 32'(err), 32'd0);

    // Fence from p0 behind two outstanding reads; p1 write waits behind it.
    p0_enable = 1'b1; p0_req = mk(MODE_READ, 4'd8); p1_enable = 1'b1; p1_req = mk(MODE_READ, 4'd7); tick();
    p1_enable = 1'b0; p0_req = mk(MODE_FENCE, 4'd9); tick();
    p0_enable = 1'b0;
    check("fence_rd1_tag", 32'(mem_req.wb_dest), 32'd7);
    tick();
    check("fence_rd2_tag", 32'(mem_req.wb_dest), 32'd8);
    p1_enable = 1'b1; p1_req = mk(MODE_WRITE, 4'd10); mem_idle = 1'b0; tick();
    p1_enable = 1'b0;
    check("fence_drain_block0", 32'(mem_enable), 32'd0);
    tick();
    check("fence_drain_block1", 32'(mem_enable), 32'd0);
    check("fence_arb_idle", 32'(arb_idle), 32'd0);
    mem_read_ack = 1'b1; #1;
    check("fence_ack1_p1", 32'(p1_read_ack), 32'd1);
    tick(); #1;
    check("fence_ack2_p0", 32'(p0_read_ack), 32'd1);
    tick(); mem_read_ack = 1'b0;
    check("fence_after_acks_block", 32'(mem_enable), 32'd0);
    tick();
    check("fence_wait_mem_idle", 32'(mem_enable), 32'd0);
    mem_idle = 1'b1; tick(); mem_idle = 1'b0;
    check("fence_issue_en", 32'(mem_enable), 32'd1);
    check("fence_issue_mode", 32'(mem_req.mode), 32'(MODE_FENCE));
    check("fence_issue_tag", 32'(mem_req.wb_dest), 32'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fence_wait_block%0d", i), 32'(mem_enable), 32'd0);
    end
    mem_idle = 1'b1; tick();
    check("fence_return_arb", 32'(mem_enable), 32'd0);
    tick();
    check("fence_p1_release_en", 32'(mem_enable), 32'd1);
    check("fence_p1_release_tag", 32'(mem_req.wb_dest), 32'd10);

    // Three enables on p0 with no downstream space: third one overflows.
    mem_available = 1'b0; p0_enable = 1'b1; p0_req = mk(MODE_WRITE, 4'd12); #1;
    check("ovf_avail0", 32'(p0_available), 32'd1);
    tick();
    check("ovf_avail1", 32'(p0_available), 32'd0);
    tick();
    check("ovf_err_before", 32'(err), 32'd0);
    check("ovf_avail2", 32'(p0_available), 32'd0);
    tick(); p0_enable = 1'b0;
    check("ovf_err_set", 32'(err), 32'd1);

    // Reset with two reads outstanding, then a stray ack.
    mem_available = 1'b1; tick(); tick();
    p0_enable = 1'b1; p0_req = mk(MODE_READ, 4'd13); p1_enable = 1'b1; p1_req = mk(MODE_READ, 4'd14); tick();
    idle_in(); tick(); tick();
    check("rst2_setup_en", 32'(mem_enable), 32'd1);
    p0_input_ready = 1'b0; p1_input_ready = 1'b0;
    rst_n = 1'b0; #2;
    check("rst2_mem_enable", 32'(mem_enable), 32'd0);
    check("rst2_mem_req_zero", 32'(mem_req != MEM_REQ_ZERO), 32'd0);
    check("rst2_err", 32'(err), 32'd0);
    check("rst2_input_ready", 32'(mem_input_ready), 32'd1);
    check("rst2_arb_idle", 32'(arb_idle), 32'd1);
    rst_n = 1'b1;
    mem_read_ack = 1'b1; #1;
    check("rst2_stray_p0_ack", 32'(p0_read_ack), 32'd0);
    check("rst2_stray_p1_ack", 32'(p1_read_ack), 32'd0);
    tick(); mem_read_ack = 1'b0;
    check("rst2_stray_err", 32'(err), 32'd1);

    // With clk_en low an enable must not be captured.
    clk_en = 1'b0; p0_enable = 1'b1; p0_req = mk(MODE_WRITE, 4'd15); tick(); tick();
    p0_enable = 1'b0; clk_en = 1'b1; #1;
    check("clken_fifo_frozen", 32'(p0_available), 32'd1);
    check("clken_arb_idle", 32'(arb_idle), 32'd1);
    check("clken_err_sticky", 32'(err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
